// File: rtl/ro_pkg.sv
// Shared encodings for the ring-buffer readout sequencer: FSM states,
// header tag and a small elaboration-time helper.
package ro_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_ARB   = 4'd1,
    ST_LOAD  = 4'd2,
    ST_HDR   = 4'd3,
    ST_HDR_W = 4'd4,
    ST_PRIME = 4'd5,
    ST_DAT   = 4'd6,
    ST_DAT_W = 4'd7,
    ST_CHECK = 4'd8,
    ST_DONE  = 4'd9
  } ro_state_e;

  localparam logic [3:0] HDR_TAG = 4'hA;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ro_sequencer_rr_arbiter.sv
// Round-robin arbiter: first set request at or after ptr_i, wrapping,
// returned as index and one-hot grant.
module rr_arbiter
  import ro_pkg::*;
#(
  parameter int NCH = 4,
  parameter int IW  = 2
) (
  input  logic [NCH-1:0] req_i,
  input  logic [IW-1:0]  ptr_i,
  output logic [NCH-1:0] grant_o,
  output logic [IW-1:0]  idx_o,
  output logic           valid_o
);

  localparam int SW = IW + 1;

  logic [NCH-1:0] rot_s;
  logic [IW-1:0]  off_s;
  logic [IW:0]    sum_s;

  // Rotate so bit 0 is the pointer position; lowest set bit is then the winner.
  assign rot_s = NCH'({req_i, req_i} >> ptr_i);

  // Priority search over the rotated vector, then map back to a channel index.
  always_comb begin
    valid_o = 1'b0;
    off_s   = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (rot_s[i]) begin
        valid_o = 1'b1;
        off_s   = IW'(i);
      end else begin
        off_s = off_s;
      end
    end
    sum_s   = {1'b0, ptr_i} + {1'b0, off_s};
    idx_o   = (sum_s >= SW'(NCH)) ? IW'(sum_s - SW'(NCH)) : IW'(sum_s);
    grant_o = valid_o ? (NCH'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/ro_sequencer.sv
// Readout scheduler: round-robin grant of ring-buffer channels onto one SPI
// link, sequencing parameter load, header word and data words per readout.
module ro_sequencer
  import ro_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int DW       = 16,
  parameter int LOAD_CYC = 2,
  parameter int RD_LAT   = 1
) (
  input  logic              sysclk,
  input  logic              rst,
  input  logic [NCH-1:0]    req,
  input  logic              ro_abort,
  input  logic [NCH-1:0]    ro_done_n,
  input  logic [NCH*DW-1:0] rb_data,
  input  logic              spi_busy,
  input  logic              spi_done,
  output logic [NCH-1:0]    rd_request,
  output logic [NCH-1:0]    spi_done_o,
  output logic              spi_start,
  output logic [DW-1:0]     spi_word,
  output logic [NCH-1:0]    ack,
  output logic              busy
);

  localparam int IW = $clog2(NCH);
  localparam int CW = $clog2(max2(LOAD_CYC, RD_LAT + 1) + 1);
  localparam logic [CW-1:0] LOAD_INIT  = CW'(LOAD_CYC - 1);
  localparam logic [CW-1:0] PRIME_INIT = (RD_LAT > 0) ? CW'(RD_LAT - 1) : '0;
  localparam logic [CW-1:0] POST_INIT  = CW'(RD_LAT);

  ro_state_e      state_q, state_d;
  logic [IW-1:0]  g_q, g_d, ptr_q, ptr_d;
  logic [NCH-1:0] gsel_q, gsel_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           pend_q, pend_d, abort_q, abort_d;
  logic [DW-1:0]  word_q, word_d, rb_sel_s;
  logic [NCH-1:0] rd_request_q, rd_request_d, ack_q, ack_d;
  logic           busy_q, busy_d;
  logic [NCH-1:0] arb_grant_s;
  logic [IW-1:0]  arb_idx_s;
  logic           arb_valid_s;

  rr_arbiter #(.NCH(NCH), .IW(IW)) u_arb (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant_s),
    .idx_o   (arb_idx_s),
    .valid_o (arb_valid_s)
  );

  assign rb_sel_s   = rb_data[g_q*DW +: DW];
  assign rd_request = rd_request_q;
  assign ack        = ack_q;
  assign busy       = busy_q;
  assign spi_word   = word_q;

  // Next-state, counters and the two launch/forward strobes.
  always_comb begin
    state_d    = state_q;
    g_d        = g_q;
    gsel_d     = gsel_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    abort_d    = abort_q;
    word_d     = word_q;
    spi_start  = 1'b0;
    spi_done_o = '0;
    case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        pend_d  = 1'b0;
        state_d = (|req) ? ST_ARB : ST_IDLE;
      end
      ST_ARB: begin
        if (arb_valid_s) begin
          g_d     = arb_idx_s;
          gsel_d  = arb_grant_s;
          ptr_d   = (arb_idx_s == IW'(NCH - 1)) ? '0 : arb_idx_s + 1'b1;
          cnt_d   = LOAD_INIT;
          state_d = ro_abort ? ST_DONE : ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (ro_abort) begin
          state_d = ST_DONE;
        end else if (cnt_q == '0) begin
          word_d             = '0;
          word_d[DW-1 -: 8]  = {HDR_TAG, 4'(g_q)};
          state_d            = ST_HDR;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_HDR: begin
        if (ro_abort) begin
          state_d = ST_DONE;
        end else if (!spi_busy) begin
          spi_start = 1'b1;
          state_d   = ST_HDR_W;
        end else begin
          state_d = ST_HDR;
        end
      end
      // The header's spi_done belongs to no address controller, so it is never forwarded.
      ST_HDR_W: begin
        if (spi_done) begin
          cnt_d = PRIME_INIT;
          if (ro_abort || abort_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = (RD_LAT > 0) ? ST_PRIME : ST_CHECK;
          end
        end else if (ro_abort) begin
          abort_d = 1'b1;
        end else begin
          state_d = ST_HDR_W;
        end
      end
      ST_PRIME: begin
        if (ro_abort) begin
          state_d = ST_DONE;
        end else if (cnt_q == '0) begin
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_CHECK: begin
        if (ro_abort || !ro_done_n[g_q]) begin
          state_d = ST_DONE;
        end else begin
          word_d  = rb_sel_s;
          state_d = ST_DAT;
        end
      end
      ST_DAT: begin
        if (ro_abort) begin
          state_d = ST_DONE;
        end else if (!spi_busy) begin
          spi_start = 1'b1;
          pend_d    = 1'b1;
          state_d   = ST_DAT_W;
        end else begin
          word_d = rb_sel_s;
        end
      end
      // pend_q: word on the wire; afterwards wait RD_LAT+1 for ro_done_n/rb_data to settle.
      ST_DAT_W: begin
        if (pend_q) begin
          if (spi_done) begin
            spi_done_o = gsel_q;
            pend_d     = 1'b0;
            cnt_d      = POST_INIT;
            state_d    = (ro_abort || abort_q) ? ST_DONE : ST_DAT_W;
          end else if (ro_abort) begin
            abort_d = 1'b1;
          end else begin
            state_d = ST_DAT_W;
          end
        end else if (ro_abort) begin
          state_d = ST_DONE;
        end else if (cnt_q == '0) begin
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so the ports come straight from flops.
  always_comb begin
    case (state_d)
      ST_PRIME, ST_CHECK, ST_DAT, ST_DAT_W: rd_request_d = gsel_d;
      default:                              rd_request_d = '0;
    endcase
    ack_d  = (state_d == ST_DONE) ? gsel_d : '0;
    busy_d = (state_d != ST_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      g_q          <= '0;
      gsel_q       <= '0;
      ptr_q        <= '0;
      cnt_q        <= '0;
      pend_q       <= 1'b0;
      abort_q      <= 1'b0;
      word_q       <= '0;
      rd_request_q <= '0;
      ack_q        <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      g_q          <= g_d;
      gsel_q       <= gsel_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      abort_q      <= abort_d;
      word_q       <= word_d;
      rd_request_q <= rd_request_d;
      ack_q        <= ack_d;
      busy_q       <= busy_d;
    end
  end

endmodule

// File: tb/tb_ro_sequencer.sv
// Scoreboard bench for ro_sequencer: behavioural SPI master and address
// controllers, expected SPI words and acks queued by the stimulus.
module tb_ro_sequencer;

  localparam int NCH = 4;
  localparam int DW  = 16;
  localparam int RD_LAT = 1;

  logic              sysclk, rst, ro_abort, spi_busy, spi_done, spi_start, busy;
  logic [NCH-1:0]    req, ro_done_n, rd_request, spi_done_o, ack;
  logic [NCH*DW-1:0] rb_data;
  logic [DW-1:0]     spi_word;

  ro_sequencer #(.NCH(NCH), .DW(DW), .LOAD_CYC(2), .RD_LAT(RD_LAT)) dut (
    .sysclk(sysclk), .rst(rst), .req(req), .ro_abort(ro_abort),
    .ro_done_n(ro_done_n), .rb_data(rb_data), .spi_busy(spi_busy), .spi_done(spi_done),
    .rd_request(rd_request), .spi_done_o(spi_done_o), .spi_start(spi_start),
    .spi_word(spi_word), .ack(ack), .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0]  exp_words[$];
  logic [NCH-1:0] exp_acks[$];

  logic           s_start, s_busy;
  logic [NCH-1:0] s_done_o, s_ack, s_rdreq;
  logic [NCH-1:0] req_set;
  logic           busy_force;
  int             howmany[NCH];
  int             acnt[NCH];
  int             done_cnt[NCH];
  int             rdreq_cyc[NCH];
  int             start_cnt = 0;

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #2;
  endtask

  task automatic push_ch(input int c, input int hm);
    exp_words.push_back({4'hA, 4'(c), 8'h00});
    for (int k = hm; k >= 1; k--) exp_words.push_back({4'hD, 4'(c), 8'(k)});
    exp_acks.push_back(NCH'(1) << c);
  endtask

  task automatic raise(input logic [NCH-1:0] m);
    req_set = m;
    tick();
    req_set = '0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (!(exp_words.size() == 0 && exp_acks.size() == 0 && s_busy == 1'b0 && req == '0)
           && k < 3000) begin
      tick();
      k++;
    end
    check({name, "_drain"}, 32'(k < 3000), 32'd1);
  endtask

  task automatic wait_rdreq(input logic [NCH-1:0] m, input string name);
    int k;
    k = 0;
    while (s_rdreq != m && k < 2000) begin
      tick();
      k++;
    end
    check({name, "_seen"}, 32'(k < 2000), 32'd1);
  endtask

  task automatic wait_starts(input int base, input int n, input string name);
    int k;
    k = 0;
    while (start_cnt - base < n && k < 2000) begin
      tick();
      k++;
    end
    check({name, "_starts"}, 32'(k < 2000), 32'd1);
  endtask

  // Environment: SPI master (3 busy cycles then a done pulse), address
  // controllers (ro_done_n and rb_data lag the remaining count by one cycle),
  // and requesters that drop req on ack.
  initial begin : model
    int scnt;
    logic busy_m;
    scnt = 0; busy_m = 1'b0;
    spi_busy = 1'b0; spi_done = 1'b0; ro_done_n = '0; rb_data = '0; req = '0;
    for (int c = 0; c < NCH; c++) acnt[c] = 0;
    forever begin
      @(posedge sysclk);
      #1;
      if (rst) begin
        scnt = 0; busy_m = 1'b0; spi_busy = 1'b0; spi_done = 1'b0; req = '0;
        for (int c = 0; c < NCH; c++) acnt[c] = 0;
      end else begin
        spi_done = 1'b0;
        if (s_start) begin
          busy_m = 1'b1;
          scnt = 3;
        end else if (scnt > 1) begin
          scnt--;
        end else if (scnt == 1) begin
          scnt = 0;
          busy_m = 1'b0;
          spi_done = 1'b1;
        end
        spi_busy = busy_m | busy_force;
        for (int c = 0; c < NCH; c++) begin
          ro_done_n[c] = (acnt[c] != 0);
          rb_data[c*DW +: DW] = {4'hD, 4'(c), 8'(acnt[c])};
          if (!s_rdreq[c]) acnt[c] = howmany[c];
          else if (s_done_o[c] && acnt[c] != 0) acnt[c]--;
        end
        req = (req & ~s_ack) | req_set;
      end
    end
  end

  // Monitor: samples on the falling edge and checks against the scoreboard.
  initial begin : monitor
    logic          inflight;
    logic [DW-1:0] held;
    inflight = 1'b0; held = '0;
    s_start = 1'b0; s_busy = 1'b0; s_done_o = '0; s_ack = '0; s_rdreq = '0;
    for (int c = 0; c < NCH; c++) begin
      done_cnt[c] = 0;
      rdreq_cyc[c] = 0;
    end
    forever begin
      @(negedge sysclk);
      s_start = spi_start; s_done_o = spi_done_o; s_ack = ack; s_rdreq = rd_request; s_busy = busy;
      if (rst) begin
        inflight = 1'b0;
      end else begin
        if (spi_start) begin
          check("start_while_busy", 32'(spi_busy), 32'd0);
          if (exp_words.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_word: got %0h expected none", spi_word);
          end else begin
            check("spi_word", 32'(spi_word), 32'(exp_words.pop_front()));
          end
          inflight = 1'b1;
          held = spi_word;
          start_cnt++;
        end else if (inflight) begin
          check("word_stable", 32'(spi_word), 32'(held));
          if (spi_done) inflight = 1'b0;
        end
        for (int c = 0; c < NCH; c++) begin
          if (spi_done_o[c]) done_cnt[c]++;
          if (rd_request[c]) rdreq_cyc[c]++;
        end
        if (ack != '0) begin
          if (exp_acks.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_ack: got %0h expected none", ack);
          end else begin
            check("ack", 32'(ack), 32'(exp_acks.pop_front()));
          end
        end
      end
    end
  end

  initial begin : stim
    int base, d0;
    rst = 1'b1; ro_abort = 1'b0; busy_force = 1'b0; req_set = '0;
    for (int c = 0; c < NCH; c++) howmany[c] = 0;
    repeat (3) tick();
    check("rst_rd_request", 32'(rd_request), 32'd0);
    check("rst_spi_done_o", 32'(spi_done_o), 32'd0);
    check("rst_spi_start", 32'(spi_start), 32'd0);
    check("rst_spi_word", 32'(spi_word), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();

    // Round robin 0,1,3 then ch0 re-requests while ch3 is being read.
    howmany[0] = 1; howmany[1] = 2; howmany[3] = 1;
    push_ch(0, 1); push_ch(1, 2); push_ch(3, 1); push_ch(0, 2);
    raise(4'b1011);
    wait_rdreq(4'b1000, "ch3_active");
    howmany[0] = 2;
    raise(4'b0001);
    wait_idle("rr_order");

    // Single channel, three data words.
    howmany[1] = 3;
    d0 = done_cnt[1];
    push_ch(1, 3);
    raise(4'b0010);
    wait_idle("ch1_three");
    check("ch1_done_o_pulses", 32'(done_cnt[1] - d0), 32'd3);

    // Empty buffer: header only.
    howmany[2] = 0;
    d0 = done_cnt[2];
    base = rdreq_cyc[2];
    push_ch(2, 0);
    raise(4'b0100);
    wait_idle("ch2_empty");
    check("ch2_done_o_pulses", 32'(done_cnt[2] - d0), 32'd0);
    check("ch2_rdreq_window", 32'((rdreq_cyc[2] - base) >= 1 && (rdreq_cyc[2] - base) <= RD_LAT + 1), 32'd1);

    // SPI busy held while the first data word is pending.
    howmany[3] = 2;
    push_ch(3, 2);
    raise(4'b1000);
    wait_rdreq(4'b1000, "ch3_prime");
    base = start_cnt;
    busy_force = 1'b1;
    repeat (10) tick();
    check("busy_hold_no_start", 32'(start_cnt - base), 32'd0);
    busy_force = 1'b0;
    wait_idle("busy_hold");

    // Abort during the second data word of five.
    howmany[0] = 5;
    d0 = done_cnt[0];
    exp_words.push_back(16'hA000); exp_words.push_back(16'hD005); exp_words.push_back(16'hD004);
    exp_acks.push_back(4'b0001);
    base = start_cnt;
    raise(4'b0001);
    wait_starts(base, 3, "abort");
    ro_abort = 1'b1;
    tick();
    ro_abort = 1'b0;
    wait_idle("abort");
    check("abort_done_o_pulses", 32'(done_cnt[0] - d0), 32'd2);
    howmany[1] = 1;
    push_ch(1, 1);
    raise(4'b0010);
    wait_idle("after_abort");

    // Reset in the middle of a data phase.
    howmany[2] = 4;
    exp_words.push_back(16'hA200); exp_words.push_back(16'hD204);
    base = start_cnt;
    raise(4'b0100);
    wait_starts(base, 2, "mid_rst");
    rst = 1'b1;
    #1;
    check("mid_rst_rd_request", 32'(rd_request), 32'd0);
    check("mid_rst_spi_done_o", 32'(spi_done_o), 32'd0);
    check("mid_rst_spi_start", 32'(spi_start), 32'd0);
    check("mid_rst_spi_word", 32'(spi_word), 32'd0);
    check("mid_rst_ack", 32'(ack), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_words_left", 32'(exp_words.size()), 32'd0);
    howmany[0] = 1; howmany[2] = 1;
    push_ch(0, 1); push_ch(2, 1);
    raise(4'b0101);
    wait_idle("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

endmodule
